// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue.
//   PERIOD          : UART bit period in CLOCK_50 cycles (50 MHz / 19200 baud)
//   DEPTH_LOG2_DEF  : default log2 of the queue depth in bytes
//   tx_state_t      : states of the transmit hand-off FSM
package uart_pkg;

    localparam int unsigned PERIOD         = 2604;
    localparam int unsigned DEPTH_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/fifo_ram_dp.sv
// Dual-port byte storage for the transmit queue: synchronous write,
// asynchronous (combinational) read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, follows raddr without a clock
module fifo_ram_dp #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage carries no reset; validity is tracked by the queue pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of a UART transmitter. Bytes written on WR are
// queued and handed to the UART one at a time with a one-cycle TXS pulse.
//   CLOCK_50 : clock, rising edge
//   RESET    : asynchronous active-high reset
//   WR_DATA  : byte to enqueue
//   WR       : enqueue strobe, one byte per cycle
//   FULL     : queue holds 2^DEPTH_LOG2 bytes
//   EMPTY    : queue holds no bytes
//   COUNT    : number of bytes queued
//   OVERFLOW : sticky, a write was dropped because the queue was full
//   CLR_OVF  : clears OVERFLOW (a simultaneous drop keeps it set)
//   TX_DATA  : byte presented to the UART, held until the next hand-off
//   TXS      : transmit-start pulse to the UART
//   TXC      : UART idle / transmit-complete flag
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned START_WAIT = 3
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [7:0]          WR_DATA,
    input  logic                WR,
    output logic                FULL,
    output logic                EMPTY,
    output logic [DEPTH_LOG2:0] COUNT,
    output logic                OVERFLOW,
    input  logic                CLR_OVF,
    output logic [7:0]          TX_DATA,
    output logic                TXS,
    input  logic                TXC
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int unsigned WW    = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    tx_state_t     state;
    logic [WW-1:0] wait_cnt;

    // A write is accepted only against the registered FULL, so a pop in the
    // same cycle never makes room for a write that arrived at full.
    assign push       = WR & ~FULL;
    assign pop        = (state == IDLE) & ~EMPTY & TXC;
    assign count_next = COUNT + CW'(push) - CW'(pop);

    fifo_ram_dp #(
        .AW (AW),
        .DW (8)
    ) u_ram (
        .clk   (CLOCK_50),
        .we    (push & ~RESET),
        .waddr (wr_ptr),
        .wdata (WR_DATA),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Queue pointers, occupancy flags and overflow flag.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            EMPTY    <= 1'b1;
            FULL     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            COUNT <= count_next;
            EMPTY <= (count_next == '0);
            FULL  <= (count_next == CW'(DEPTH));
            if (WR & FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

    // Hand-off FSM: pop into TX_DATA, pulse TXS, then follow TXC through
    // the frame. If the UART never drops TXC the byte is abandoned.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            TXS      <= 1'b0;
            TX_DATA  <= 8'h00;
            wait_cnt <= '0;
        end else begin
            TXS <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= LOAD;
                        TXS     <= 1'b1;
                        TX_DATA <= head;
                    end
                end
                LOAD: begin
                    state    <= WAIT_START;
                    wait_cnt <= '0;
                end
                WAIT_START: begin
                    if (!TXC) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == WW'(START_WAIT - 1)) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (TXC) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: per-cycle vector table with manual TXC,
// then hand-written sequences using a small UART model.
module tb_uart_tx_fifo;

    localparam int unsigned BIT = 4;

    typedef struct packed {
        logic       wr;
        logic [7:0] wd;
        logic       txc;
        logic [4:0] cnt;
        logic       empty;
        logic       full;
        logic       txs;
        logic       ovf;
        logic [7:0] txd;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] wd;
    logic       wr;
    logic       clr;
    logic       man_txc;
    logic       model_en;
    logic       model_txc;
    logic       txc;
    logic       tx_line;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;
    logic [7:0] tx_data;
    logic       txs;

    logic [7:0] rx_q[$];
    logic       line_q[$];
    logic [7:0] mdl_byte;
    logic [9:0] mdl_frame;

    int pass_cnt;
    int total_cnt;

    assign txc = model_en ? model_txc : man_txc;

    uart_tx_fifo #(
        .DEPTH_LOG2 (4),
        .START_WAIT (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .WR_DATA  (wd),
        .WR       (wr),
        .FULL     (full),
        .EMPTY    (empty),
        .COUNT    (count),
        .OVERFLOW (ovf),
        .CLR_OVF  (clr),
        .TX_DATA  (tx_data),
        .TXS      (txs),
        .TXC      (txc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: on TXS latch the byte, drop TXC, shift a 10-bit frame.
    initial begin
        model_txc = 1'b1;
        tx_line   = 1'b1;
        mdl_byte  = 8'h00;
        mdl_frame = 10'h3FF;
        forever begin
            @(posedge clk);
            #1;
            if (model_en && txs) begin
                mdl_byte = tx_data;
                rx_q.push_back(mdl_byte);
                model_txc = 1'b0;
                mdl_frame = {1'b1, mdl_byte, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    tx_line = mdl_frame[i];
                    line_q.push_back(mdl_frame[i]);
                    repeat (BIT) @(posedge clk);
                end
                #1;
                model_txc = 1'b1;
                tx_line   = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic t, input logic c);
        wr      = w;
        wd      = d;
        man_txc = t;
        clr     = c;
    endtask

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic t,
                                input logic [4:0] c, input logic e, input logic f,
                                input logic s, input logic o, input logic [7:0] x);
        vec_t v;
        v.wr = w; v.wd = d; v.txc = t; v.cnt = c; v.empty = e;
        v.full = f; v.txs = s; v.ovf = o; v.txd = x;
        return v;
    endfunction

    vec_t tbl[25];

    initial begin
        int n;
        int txs_seen;
        logic [9:0] line_val;

        pass_cnt  = 0;
        total_cnt = 0;
        model_en  = 1'b0;
        rst       = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // latency, stuck TXC, no resend, write+pop at COUNT=5
        tbl[0]  = mk(1, 8'hA5, 1, 1, 0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 8'hA5);
        tbl[2]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'hA5);
        tbl[3]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'hA5);
        tbl[4]  = mk(1, 8'h3C, 0, 1, 0, 0, 0, 0, 8'hA5);
        tbl[5]  = mk(1, 8'h7E, 0, 2, 0, 0, 0, 0, 8'hA5);
        tbl[6]  = mk(0, 8'h00, 1, 2, 0, 0, 0, 0, 8'hA5);
        tbl[7]  = mk(0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h3C);
        tbl[8]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h3C);
        tbl[9]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h3C);
        tbl[10] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h3C);
        tbl[11] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h3C);
        tbl[12] = mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 8'h7E);
        tbl[13] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h7E);
        tbl[14] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h7E);
        tbl[15] = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h7E);
        tbl[16] = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h7E);
        tbl[17] = mk(1, 8'h01, 0, 1, 0, 0, 0, 0, 8'h7E);
        tbl[18] = mk(1, 8'h02, 0, 2, 0, 0, 0, 0, 8'h7E);
        tbl[19] = mk(1, 8'h03, 0, 3, 0, 0, 0, 0, 8'h7E);
        tbl[20] = mk(1, 8'h04, 0, 4, 0, 0, 0, 0, 8'h7E);
        tbl[21] = mk(1, 8'h05, 0, 5, 0, 0, 0, 0, 8'h7E);
        tbl[22] = mk(1, 8'h06, 1, 5, 0, 0, 1, 0, 8'h01);
        tbl[23] = mk(0, 8'h00, 0, 5, 0, 0, 0, 0, 8'h01);
        tbl[24] = mk(0, 8'h00, 0, 5, 0, 0, 0, 0, 8'h01);

        // reset values, before any clock edge
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_txs", 32'(txs), 0);
        check("rst_txdata", 32'(tx_data), 32'h00);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].wr, tbl[i].wd, tbl[i].txc, 1'b0);
            tick();
            check($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
            check($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].full));
            check($sformatf("v%0d_txs", i), 32'(txs), 32'(tbl[i].txs));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            check($sformatf("v%0d_txdata", i), 32'(tx_data), 32'(tbl[i].txd));
        end

        // fill to full while the UART is busy (state WAIT_DONE, COUNT=5)
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 8'(8'h07 + i), 1'b0, 1'b0);
            tick();
        end
        check("fill_count", 32'(count), 16);
        check("fill_full", 32'(full), 1);
        check("fill_ovf", 32'(ovf), 0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        tick();
        check("drop_count", 32'(count), 16);
        check("drop_ovf", 32'(ovf), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("clr_ovf", 32'(ovf), 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("pre_pop_txs", 32'(txs), 0);
        // write at full coinciding with a pop, with CLR_OVF also high
        drive(1'b1, 8'h99, 1'b1, 1'b1);
        tick();
        check("fullpop_count", 32'(count), 15);
        check("fullpop_full", 32'(full), 0);
        check("fullpop_ovf", 32'(ovf), 1);
        check("fullpop_txs", 32'(txs), 1);
        check("fullpop_txdata", 32'(tx_data), 32'h02);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("clr_ovf2", 32'(ovf), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        // drain the rest through the UART model; order across pointer wrap
        rx_q.delete();
        model_en = 1'b1;
        n = 0;
        while (rx_q.size() < 15 && n < 3000) begin
            tick();
            n++;
        end
        check("drain_size", 32'(rx_q.size()), 15);
        for (int i = 0; i < rx_q.size(); i++) begin
            check($sformatf("drain_byte%0d", i), 32'(rx_q[i]), 32'(3 + i));
        end
        n = 0;
        while (!(model_txc && empty) && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();

        // single byte: latency and serial line content
        rx_q.delete();
        line_q.delete();
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("lat_cyc1_txs", 32'(txs), 0);
        tick();
        check("lat_cyc2_txs", 32'(txs), 1);
        check("lat_cyc2_txdata", 32'(tx_data), 32'hA5);
        n = 0;
        while (line_q.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        check("line_bits", 32'(line_q.size()), 10);
        line_val = '0;
        for (int i = 0; i < 10 && i < line_q.size(); i++) begin
            line_val[i] = line_q[i];
        end
        check("line_frame", 32'(line_val), 32'h34A);
        n = 0;
        while (!model_txc && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();

        // 0x00..0x1F in two bursts of 16
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n = 0;
        while (!empty && n < 1500) begin
            tick();
            n++;
        end
        check("burst1_empty", 32'(empty), 1);
        for (int i = 16; i < 32; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("burst2_count", 32'(count), 16);
        check("burst2_ovf", 32'(ovf), 0);
        n = 0;
        while (rx_q.size() < 32 && n < 3000) begin
            tick();
            n++;
        end
        check("order_size", 32'(rx_q.size()), 32);
        for (int i = 0; i < rx_q.size(); i++) begin
            check($sformatf("order_byte%0d", i), 32'(rx_q[i]), 32'(i));
        end
        n = 0;
        while (!(model_txc && empty) && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();

        // reset mid-frame with four bytes still queued
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        check("mid_count", 32'(count), 4);
        check("mid_busy", 32'(model_txc), 0);
        #2;
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        #1;
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_full", 32'(full), 0);
        check("mrst_ovf", 32'(ovf), 0);
        check("mrst_txs", 32'(txs), 0);
        check("mrst_txdata", 32'(tx_data), 32'h00);
        tick();
        tick();
        check("mrst_wr_count", 32'(count), 0);
        check("mrst_wr_ovf", 32'(ovf), 0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        txs_seen = 0;
        n = 0;
        while (!model_txc && n < 200) begin
            tick();
            if (txs) txs_seen++;
            n++;
        end
        check("post_rst_frame_end", 32'(model_txc), 1);
        repeat (6) begin
            tick();
            if (txs) txs_seen++;
        end
        check("post_rst_txs", 32'(txs_seen), 0);
        check("post_rst_rx", 32'(rx_q.size()), 1);
        check("post_rst_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
